// File: rtl/cdc_pulse_sched.sv
// cdc_pulse_sched: serialises per-requester event pulses onto one pulse_f line with a guard gap.
// Sticky per-requester overflow flags are built only when CDC_PULSE_SCHED_OVF_EN is defined.
module cdc_pulse_sched #(
  parameter int N_REQ = 4,
  parameter int GAP   = 8,
  parameter int CNT_W = 3
) (
  input  logic                     clk_f,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_pulse,
  input  logic                     ovf_clr,
  output logic                     pulse_f,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic [N_REQ-1:0]         ovf_flag
);

  // state   | meaning
  // ST_IDLE | nothing in flight, waiting for any pending count
  // ST_FIRE | one-cycle pulse_f for the latched grantee
  // ST_GAP  | GAP-cycle guard so the slow side sees separate pulses

  localparam int ID_W = $clog2(N_REQ);
  localparam int GW   = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FIRE, ST_GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pending_q [N_REQ];
  logic [N_REQ-1:0] pend_nz;
  logic [N_REQ-1:0] dec;
  logic [N_REQ-1:0] ovf_evt;
  logic             any_pend;
  logic             gap_done;
  logic             fire_go;
  logic             found;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  grant_q;
  logic [GW-1:0]    gap_cnt_q;
  int               srch_idx;

  always_comb begin
    pend_nz = '0;
    for (int i = 0; i < N_REQ; i++) pend_nz[i] = |pending_q[i];
  end

  assign any_pend = |pend_nz;
  assign gap_done = (gap_cnt_q == '0);

  // Round-robin search from rr_ptr, first nonzero counter wins
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    srch_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      srch_idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!found && pend_nz[srch_idx]) begin
        found  = 1'b1;
        winner = ID_W'(srch_idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fire_go = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_pend) begin
          state_d = ST_FIRE;
          fire_go = 1'b1;
        end
      end
      ST_FIRE: state_d = ST_GAP;
      ST_GAP: begin
        if (gap_done) begin
          if (any_pend) begin
            state_d = ST_FIRE;
            fire_go = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dec     = '0;
    ovf_evt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      dec[i]     = fire_go && (winner == ID_W'(i));
      ovf_evt[i] = req_pulse[i] && !dec[i] && (pending_q[i] == '1);
    end
  end

  always_ff @(posedge clk_f or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_f or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_q <= '0;
    end else if (state_q == ST_FIRE) begin
      gap_cnt_q <= GW'(GAP - 1);
    end else if (state_q == ST_GAP && !gap_done) begin
      gap_cnt_q <= gap_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_f or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else if (fire_go) begin
      grant_q  <= winner;
      rr_ptr_q <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Simultaneous inc and dec cancel; a lone inc at all-ones saturates
  always_ff @(posedge clk_f or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) pending_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_pulse[i] && !dec[i]) begin
          if (pending_q[i] != '1) pending_q[i] <= pending_q[i] + 1'b1;
        end else if (!req_pulse[i] && dec[i]) begin
          pending_q[i] <= pending_q[i] - 1'b1;
        end
      end
    end
  end

`ifdef CDC_PULSE_SCHED_OVF_EN
  logic [N_REQ-1:0] ovf_q;

  always_ff @(posedge clk_f or negedge rst_n) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= (ovf_clr ? '0 : ovf_q) | ovf_evt;
  end

  assign ovf_flag = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^{ovf_clr, ovf_evt};
  assign ovf_flag   = '0;
`endif

  assign pulse_f  = (state_q == ST_FIRE);
  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE) || any_pend;

endmodule

// File: tb/tb_cdc_pulse_sched.sv
// tb_cdc_pulse_sched: scoreboard bench for cdc_pulse_sched (N_REQ=4, GAP=8, CNT_W=3).
// Expected grant ids are queued at stimulus time and popped whenever pulse_f is observed.
module tb_cdc_pulse_sched;
  localparam int N_REQ = 4;
  localparam int GAP   = 8;
  localparam int CNT_W = 3;

  logic             clk_f = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_REQ-1:0] req_pulse = '0;
  logic             ovf_clr = 1'b0;
  logic             pulse_f;
  logic [1:0]       grant_id;
  logic             busy;
  logic [N_REQ-1:0] ovf_flag;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_q[$];
  int pulse_cyc_q[$];

  cdc_pulse_sched #(.N_REQ(N_REQ), .GAP(GAP), .CNT_W(CNT_W)) dut (
    .clk_f    (clk_f),
    .rst_n    (rst_n),
    .req_pulse(req_pulse),
    .ovf_clr  (ovf_clr),
    .pulse_f  (pulse_f),
    .grant_id (grant_id),
    .busy     (busy),
    .ovf_flag (ovf_flag)
  );

  always #5 clk_f = ~clk_f;
  always @(posedge clk_f) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Scoreboard consumer: every pulse must match the oldest queued grantee
  always @(negedge clk_f) begin
    if (pulse_f) begin
      pulse_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_pulse", 32'(1), 32'(0));
      else chk("grant_id", 32'(grant_id), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk_f);
    #1;
  endtask

  task automatic drive(input logic [N_REQ-1:0] v);
    req_pulse = v;
    tick();
    req_pulse = '0;
  endtask

  task automatic do_reset();
    @(posedge clk_f);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_pulse_f",  32'(pulse_f),  32'(0));
    chk("rst_grant_id", 32'(grant_id), 32'(0));
    chk("rst_busy",     32'(busy),     32'(0));
    chk("rst_ovf_flag", 32'(ovf_flag), 32'(0));
    exp_q.delete();
    req_pulse = '0;
    ovf_clr   = 1'b0;
    repeat (2) @(posedge clk_f);
    #3;
    rst_n = 1'b1;
    pulse_cyc_q.delete();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < budget), 32'(1));
    chk({tag, "_left"}, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic chk_spacing(input string tag, input int n_exp);
    chk({tag, "_npulse"}, 32'(pulse_cyc_q.size()), 32'(n_exp));
    for (int i = 1; i < pulse_cyc_q.size(); i++)
      chk({tag, "_space"}, 32'(pulse_cyc_q[i] - pulse_cyc_q[i-1]), 32'(GAP + 1));
  endtask

  initial begin
    logic [N_REQ-1:0] ovf_exp;
`ifdef CDC_PULSE_SCHED_OVF_EN
    ovf_exp = 4'b0010;
`else
    ovf_exp = 4'b0000;
`endif

    #2;
    chk("init_pulse_f", 32'(pulse_f), 32'(0));
    chk("init_busy",    32'(busy),    32'(0));
    chk("init_grant",   32'(grant_id), 32'(0));
    chk("init_ovf",     32'(ovf_flag), 32'(0));
    #10;
    rst_n = 1'b1;
    tick();

    // single request: latency, one-cycle pulse, busy drop after the gap
    exp_q.push_back(2);
    drive(4'b0100);
    chk("lat_edge_t_pulse", 32'(pulse_f), 32'(0));
    chk("lat_edge_t_busy",  32'(busy),    32'(1));
    tick();
    chk("lat_fire_pulse", 32'(pulse_f), 32'(1));
    chk("lat_fire_grant", 32'(grant_id), 32'(2));
    for (int i = 0; i < GAP; i++) begin
      tick();
      chk("gap_pulse", 32'(pulse_f), 32'(0));
      chk("gap_busy",  32'(busy),    32'(1));
    end
    tick();
    chk("gap_end_busy", 32'(busy), 32'(0));
    chk("grant_hold", 32'(grant_id), 32'(2));
    drain("single", 50);

    // all four at once: 0,1,2,3 exactly GAP+1 apart
    do_reset();
    for (int i = 0; i < N_REQ; i++) exp_q.push_back(i);
    drive(4'b1111);
    drain("burst", 200);
    chk_spacing("burst", 4);

    // grant to 3, then 0 and 3 pending: wrap to 0
    do_reset();
    exp_q.push_back(3);
    drive(4'b1000);
    repeat (3) tick();
    exp_q.push_back(0);
    exp_q.push_back(3);
    drive(4'b1001);
    drain("wrap", 200);
    chk_spacing("wrap", 3);

    // pointer resumes after previous winner (2 -> search starts at 3)
    do_reset();
    exp_q.push_back(2);
    drive(4'b0100);
    repeat (3) tick();
    exp_q.push_back(3);
    exp_q.push_back(0);
    drive(4'b1001);
    drain("rr_resume", 200);
    chk_spacing("rr_resume", 3);

    // nine back-to-back requests on 1: saturate at 7, one event lost
    do_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back(1);
    req_pulse = 4'b0010;
    repeat (9) tick();
    req_pulse = '0;
    chk("sat_ovf_set", 32'(ovf_flag), 32'(ovf_exp));
    drain("sat", 300);
    chk_spacing("sat", 8);
    chk("sat_ovf_sticky", 32'(ovf_flag), 32'(ovf_exp));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("sat_ovf_clr", 32'(ovf_flag), 32'(0));

    // inc and dec on the FIRE entry edge cancel: second pulse GAP+1 later
    do_reset();
    exp_q.push_back(0);
    exp_q.push_back(0);
    req_pulse = 4'b0001;
    tick();
    tick();
    req_pulse = '0;
    drain("incdec", 100);
    chk_spacing("incdec", 2);

    // reset during GAP with three events pending: all discarded
    do_reset();
    for (int i = 0; i < N_REQ; i++) exp_q.push_back(i);
    drive(4'b1111);
    repeat (4) tick();
    chk("pre_rst_npulse", 32'(pulse_cyc_q.size()), 32'(1));
    chk("pre_rst_busy",   32'(busy), 32'(1));
    do_reset();
    repeat (30) tick();
    chk("post_rst_npulse", 32'(pulse_cyc_q.size()), 32'(0));
    chk("post_rst_busy",   32'(busy), 32'(0));
    exp_q.push_back(1);
    drive(4'b0010);
    drain("post_rst", 50);
    chk_spacing("post_rst", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
